// File: rtl/mpadd_pkg.sv
// Shared constants and FSM encoding for the mpadd round-robin scheduler.
package mpadd_pkg;
  localparam int OP_W  = 256;
  localparam int SUM_W = OP_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set req bit at or after ptr, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx,
  output logic          vld
);
  always_comb begin
    int j;
    j      = 0;
    onehot = '0;
    idx    = '0;
    vld    = 1'b0;
    // Walk from farthest to nearest so the closest hit is the last one written.
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        onehot    = '0;
        onehot[j] = 1'b1;
        idx       = PW'(j);
        vld       = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mpadd_rr_sched.sv
// Round-robin arbiter sharing one mpadd core between NUM_REQ clients.
// Optional WAIT watchdog enabled by MPADD_RR_TIMEOUT_EN.
module mpadd_rr_sched #(
  parameter int NUM_REQ        = 4,
  parameter int OP_W           = mpadd_pkg::OP_W,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*OP_W-1:0] req_a,
  input  logic [NUM_REQ*OP_W-1:0] req_b,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [NUM_REQ-1:0]      done,
  output logic [OP_W:0]           s_out,
  output logic                    err,
  output logic                    busy,
  output logic [OP_W-1:0]         add_a,
  output logic [OP_W-1:0]         add_b,
  output logic                    add_write,
  output logic                    add_start,
  input  logic                    add_ready,
  input  logic [OP_W:0]           add_s
);
  import mpadd_pkg::*;

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("mpadd_rr_sched: unsupported NUM_REQ or TIMEOUT_CYCLES");
  end

  state_t             st;
  logic [PW-1:0]      rr_ptr, idx, pick_idx;
  logic [NUM_REQ-1:0] pick_oh;
  logic               pick_vld;

  rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .vld    (pick_vld)
  );

  assign busy = (st != ST_IDLE);

`ifdef MPADD_RR_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd;
  logic            err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st        <= ST_IDLE;
      rr_ptr    <= '0;
      idx       <= '0;
      gnt       <= '0;
      done      <= '0;
      s_out     <= '0;
      add_a     <= '0;
      add_b     <= '0;
      add_write <= 1'b0;
      add_start <= 1'b0;
`ifdef MPADD_RR_TIMEOUT_EN
      wd        <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      add_write <= 1'b0;
      add_start <= 1'b0;
      done      <= '0;
`ifdef MPADD_RR_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
      case (st)
        ST_IDLE: if (pick_vld) begin
          gnt       <= pick_oh;
          idx       <= pick_idx;
          add_a     <= req_a[int'(pick_idx)*OP_W +: OP_W];
          add_b     <= req_b[int'(pick_idx)*OP_W +: OP_W];
          add_write <= 1'b1;
          st        <= ST_WRITE;
        end
        ST_WRITE: begin
          add_start <= 1'b1;
          st        <= ST_START;
        end
        ST_START: begin
`ifdef MPADD_RR_TIMEOUT_EN
          wd <= '0;
`endif
          st <= ST_WAIT;
        end
        ST_WAIT: begin
          // Ready beats the watchdog when both land on the same cycle.
          if (add_ready) begin
            s_out <= add_s;
            done  <= gnt;
            st    <= ST_DONE;
          end
`ifdef MPADD_RR_TIMEOUT_EN
          else if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
            s_out <= '1;
            done  <= gnt;
            err_q <= 1'b1;
            st    <= ST_DONE;
          end else begin
            wd <= wd + 1'b1;
          end
`endif
        end
        ST_DONE: begin
          gnt    <= '0;
          rr_ptr <= PW'((int'(idx) + 1) % NUM_REQ);
          st     <= ST_IDLE;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mpadd_rr_sched.sv
// Self-checking bench for mpadd_rr_sched with a latency-programmable core model.
module tb_mpadd_rr_sched;
  localparam int N  = 4;
  localparam int W  = 256;
  localparam int SW = W + 1;
  localparam int TO = 64;

  logic          CLK = 1'b0;
  logic          RST;
  logic [N-1:0]  req;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]  gnt, done;
  logic [SW-1:0] s_out, add_s;
  logic          err, busy, add_write, add_start, add_ready;
  logic [W-1:0]  add_a, add_b;

  always #5 CLK = ~CLK;

  mpadd_rr_sched #(.NUM_REQ(N), .OP_W(W), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST(RST), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .done(done), .s_out(s_out), .err(err), .busy(busy),
    .add_a(add_a), .add_b(add_b), .add_write(add_write), .add_start(add_start),
    .add_ready(add_ready), .add_s(add_s)
  );

  // Core model: ready rises lat cycles after start is seen; lat==0 never finishes.
  int lat;
  int cnt_c;
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      add_ready <= 1'b0;
      cnt_c     <= 0;
      add_s     <= '0;
    end else if (add_start) begin
      add_ready <= 1'b0;
      cnt_c     <= lat;
      add_s     <= {1'b0, add_a} + {1'b0, add_b};
    end else if (cnt_c != 0) begin
      cnt_c <= cnt_c - 1;
      if (cnt_c == 1) add_ready <= 1'b1;
    end
  end

  int checks = 0;
  int errors = 0;
  int mptr   = 0;
  int done_cnt [N];

  task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic rand_lanes();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = rand_w();
      req_b[i*W +: W] = rand_w();
    end
  endtask

  // Serve one operation with req already driven; ends on the IDLE cycle after DONE.
  task automatic serve(input logic [N-1:0] r_mid, input logic [N-1:0] r_end,
                       input bit exp_to, output int win, output logic [SW-1:0] sum);
    int c;
    int e;
    logic [SW-1:0] es;
    e   = pick(req, mptr);
    win = -1;
    sum = '0;
    c   = 0;
    while (gnt == '0 && c < 40) begin @(negedge CLK); c++; end
    chk("gnt_wait", SW'(c < 40), SW'(1));
    if (c >= 40 || e < 0) return;
    chk("gnt_onehot", SW'(gnt), SW'(1 << e));
    es = {1'b0, req_a[e*W +: W]} + {1'b0, req_b[e*W +: W]};
    rand_lanes();
    c = 0;
    do begin
      @(negedge CLK);
      c++;
      if (c == 2) req = r_mid;
    end while (done == '0 && c < 200);
    chk("done_latency", SW'(c), exp_to ? SW'(2 + TO) : SW'(3 + lat));
    chk("done_onehot", SW'(done), SW'(1 << e));
    chk("sum", s_out, exp_to ? {SW{1'b1}} : es);
    chk("err", SW'(err), SW'(exp_to));
    win = e;
    sum = s_out;
    req = r_end;
    mptr = (e + 1) % N;
    done_cnt[e]++;
    @(negedge CLK);
    chk("post_done", SW'({done, gnt, busy}), SW'(0));
  endtask

  typedef struct {
    logic [N-1:0]  r;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    int            l;
    int            wi;
    logic [SW-1:0] es;
  } vec_t;

  vec_t tv [6];
  int w, maxw;
  int waits [N];
  logic [SW-1:0] sm;
  logic [N-1:0] rq, nr;
  logic [W-1:0] half;

  initial begin
    half  = '0;
    half[W-1] = 1'b1;
    tv[0] = '{4'b0001, 256'd1, {W{1'b1}}, 8, 0, {1'b1, 256'd0}};
    tv[1] = '{4'b0011, 256'd5, 256'd7, 3, 1, 257'd12};
    tv[2] = '{4'b1001, {W{1'b1}}, {W{1'b1}}, 2, 3, {1'b1, {255{1'b1}}, 1'b0}};
    tv[3] = '{4'b1110, half, half, 1, 1, {1'b1, 256'd0}};
    tv[4] = '{4'b0011, 256'd0, 256'd0, 5, 0, 257'd0};
    tv[5] = '{4'b0100, 256'd123, 256'd456, 1, 2, 257'd579};

    RST = 1'b1; req = '0; req_a = '0; req_b = '0; lat = 1;
    for (int i = 0; i < N; i++) begin done_cnt[i] = 0; waits[i] = 0; end
    repeat (3) @(negedge CLK);
    chk("rst_ctl", SW'({gnt, done, err, busy, add_write, add_start}), SW'(0));
    chk("rst_sum", s_out, '0);
    chk("rst_ops", SW'(add_a | add_b), '0);
    RST = 1'b0;
    @(negedge CLK);

    // Directed table from rr_ptr = 0.
    for (int v = 0; v < 6; v++) begin
      lat = tv[v].l;
      rand_lanes();
      req_a[tv[v].wi*W +: W] = tv[v].a;
      req_b[tv[v].wi*W +: W] = tv[v].b;
      req = tv[v].r;
      serve(tv[v].r, '0, 1'b0, w, sm);
      chk("tbl_win", SW'(w), SW'(tv[v].wi));
      chk("tbl_sum", sm, tv[v].es);
    end

    // All requesters held: strict rotation, equal share.
    for (int i = 0; i < N; i++) done_cnt[i] = 0;
    req = 4'b1111;
    rand_lanes();
    for (int k = 0; k < 16; k++) begin
      lat = $urandom_range(1, 4);
      serve(4'b1111, (k == 15) ? 4'b0000 : 4'b1111, 1'b0, w, sm);
      chk("rot_order", SW'(w), SW'((3 + k) % N));
    end
    for (int i = 0; i < N; i++) chk("rot_share", SW'(done_cnt[i]), SW'(4));

    // Requester 2 drops req mid-operation; 3 raises and is next.
    lat = 4;
    req = 4'b0100;
    serve(4'b1000, 4'b1000, 1'b0, w, sm);
    chk("drop_win", SW'(w), SW'(2));
    serve(4'b1000, 4'b0000, 1'b0, w, sm);
    chk("drop_next", SW'(w), SW'(3));

    // Reset during WAIT after moving rr_ptr off zero.
    lat = 2;
    req = 4'b0001;
    serve(4'b0001, 4'b0000, 1'b0, w, sm);
    lat = 8;
    req = 4'b0100;
    begin
      int c;
      c = 0;
      while (gnt == '0 && c < 40) begin @(negedge CLK); c++; end
      repeat (3) @(negedge CLK);
      req = '0;
      RST = 1'b1;
      #1;
      chk("arst_ctl", SW'({gnt, done, err, busy, add_write, add_start}), SW'(0));
      chk("arst_sum", s_out, '0);
      chk("arst_ops", SW'(add_a | add_b), '0);
      for (int k = 0; k < 3; k++) begin
        @(negedge CLK);
        chk("arst_nodone", SW'(done), SW'(0));
      end
      RST = 1'b0;
      mptr = 0;
      @(negedge CLK);
    end
    lat = 3;
    req = 4'b0101;
    serve(4'b0101, 4'b0000, 1'b0, w, sm);
    chk("arst_ptr", SW'(w), SW'(0));

`ifdef MPADD_RR_TIMEOUT_EN
    lat = 0;
    req = 4'b0010;
    serve(4'b0010, 4'b0000, 1'b1, w, sm);
    chk("to_win", SW'(w), SW'(1));
    lat = 3;
    req = 4'b0100;
    serve(4'b0100, 4'b0000, 1'b0, w, sm);
    chk("to_next", SW'(w), SW'(2));
`endif

    // Random traffic with pending requests held until served.
    maxw = 0;
    req  = 4'($urandom_range(1, 15));
    rand_lanes();
    for (int op = 0; op < 1000; op++) begin
      lat = $urandom_range(1, 6);
      rq  = req;
      serve(req, req, 1'b0, w, sm);
      if (w < 0) break;
      for (int i = 0; i < N; i++) begin
        if (i == w || !rq[i]) waits[i] = 0;
        else waits[i]++;
        if (waits[i] > maxw) maxw = waits[i];
      end
      nr = 4'($urandom_range(0, 15));
      req = (rq & ~(4'(1) << w)) | nr;
      if (req == '0) req = 4'(1) << $urandom_range(0, N - 1);
    end
    chk("starve", SW'(maxw <= N - 1), SW'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
